// File: rtl/pixie_dma_fetch.sv
// pixie_dma_fetch: CDP1802-style DMA-out / interrupt-acknowledge sequencer
// feeding display bytes from work RAM to the cdp1861 video controller.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no bus activity, waiting for DMAO or INT (sc=00)
// S_DMA  | DMA-out machine cycle: fetch RAM[R0], R0 += 1 (sc=10)
// S_INT  | interrupt acknowledge: R0 <= frame_base (sc=11)
//
// The state encoding equals the SC code, so sc is driven straight from state.
module pixie_dma_fetch #(
  parameter int AW      = 12,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          dma_req,
  input  logic          int_req,
  input  logic [AW-1:0] frame_base,
  output logic          ram_cs,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_dout,
  output logic [7:0]    data_out,
  output logic [1:0]    sc,
  output logic          tpa,
  output logic          tpb,
  output logic [AW-1:0] ptr,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_DMA  = 2'b10;
  localparam logic [1:0] S_INT  = 2'b11;

  // ram_addr is loaded one tick ahead so it is already valid while ram_cs is high
  localparam logic [2:0] CYC_ADDR = 3'd1;
  localparam logic [2:0] CYC_CS   = 3'd2;
  localparam logic [2:0] CYC_CAP  = 3'(2 + RAM_LAT);
  localparam logic [2:0] CYC_TPA  = 3'd1;
  localparam logic [2:0] CYC_TPB  = 3'd6;
  localparam logic [2:0] CYC_END  = 3'd7;

  logic [2:0] cyc;
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       eom;

  assign eom = ce && (cyc == CYC_END);

  // Next-state decode; DMA has priority over INT, INT always returns to IDLE
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE, S_DMA: begin
        if (dma_req)      state_nxt = S_DMA;
        else if (int_req) state_nxt = S_INT;
      end
      default:            state_nxt = S_IDLE;
    endcase
  end

  // Machine-cycle tick counter, 8 ce ticks per machine cycle
  always_ff @(posedge clk) begin
    if (reset)   cyc <= 3'd0;
    else if (ce) cyc <= cyc + 3'd1;
  end

  // State register, advanced only at the end of a machine cycle
  always_ff @(posedge clk) begin
    if (reset)    state <= S_IDLE;
    else if (eom) state <= state_nxt;
  end

  // R0: post-increment after a DMA byte, reload from frame_base on INT acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (eom) begin
      if (state == S_DMA)      ptr <= ptr + AW'(1);
      else if (state == S_INT) ptr <= frame_base;
    end
  end

  // RAM address latch; holds its last value outside DMA cycles
  always_ff @(posedge clk) begin
    if (reset)                                         ram_addr <= '0;
    else if (ce && state == S_DMA && cyc == CYC_ADDR) ram_addr <= ptr;
  end

  // Byte capture once the bram latency has elapsed; stays put through tpb
  always_ff @(posedge clk) begin
    if (reset)                                        data_out <= 8'h00;
    else if (ce && state == S_DMA && cyc == CYC_CAP) data_out <= ram_dout;
  end

  assign ram_cs = (state == S_DMA) && (cyc == CYC_CS);
  assign sc     = state;
  assign busy   = (state != S_IDLE);
  assign tpa    = (cyc == CYC_TPA);
  assign tpb    = (cyc == CYC_TPB);

endmodule

// File: tb/tb_pixie_dma_fetch.sv
// Testbench for pixie_dma_fetch: directed scenarios plus a random request
// mix, checked against a machine-cycle-level reference model.
module tb_pixie_dma_fetch;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce;
  logic          dma_req;
  logic          int_req;
  logic [AW-1:0] frame_base;
  logic          ram_cs;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic [7:0]    data_out;
  logic [1:0]    sc;
  logic          tpa;
  logic          tpb;
  logic [AW-1:0] ptr;
  logic          busy;

  pixie_dma_fetch #(.AW(AW), .RAM_LAT(1)) dut (
    .clk(clk), .reset(reset), .ce(ce), .dma_req(dma_req), .int_req(int_req),
    .frame_base(frame_base), .ram_cs(ram_cs), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .data_out(data_out), .sc(sc), .tpa(tpa), .tpb(tpb),
    .ptr(ptr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Work RAM: one ce tick of read latency
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (ce && ram_cs) ram_dout <= mem[ram_addr];

  // Reference model: machine-cycle kind (0 idle, 1 dma, 2 int), R0, last byte, last address
  int            m_state;
  logic [AW-1:0] m_ptr;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic logic [1:0] sc_of(input int s);
    case (s)
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One ce tick preceded by 0..2 idle clocks, during which nothing may move
  task automatic tick(input logic [1:0] exp_sc, input int k);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      ce = 1'b0;
      @(posedge clk); #1;
      check("hold_sc", sc, exp_sc);
      check("hold_tpa", tpa, k == 1);
    end
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  // Runs one full machine cycle with the given requests and checks it tick by tick
  task automatic machine_cycle(input logic dma, input logic intr);
    logic       is_dma;
    logic       is_int;
    logic [7:0] exp_byte;
    dma_req  = dma;
    int_req  = intr;
    is_dma   = (m_state == 1);
    is_int   = (m_state == 2);
    exp_byte = mem[m_ptr];
    for (int k = 0; k < 8; k++) begin
      check("tpa", tpa, k == 1);
      check("tpb", tpb, k == 6);
      check("ram_cs", ram_cs, is_dma && (k == 2));
      if (k == 0) begin
        check("sc", sc, sc_of(m_state));
        check("busy", busy, m_state != 0);
        check("ptr", ptr, m_ptr);
        check("data_hold", data_out, m_data);
      end
      if (k == 2) begin
        if (is_dma) m_addr = m_ptr;
        check("ram_addr", ram_addr, m_addr);
      end
      if (k == 6) check("data_at_tpb", data_out, is_dma ? exp_byte : m_data);
      tick(sc_of(m_state), k);
    end
    if (is_dma) begin
      m_data = exp_byte;
      m_ptr  = m_ptr + 1'b1;
    end else if (is_int) begin
      m_ptr  = frame_base;
    end
    if (is_int)    m_state = 0;
    else if (dma)  m_state = 1;
    else if (intr) m_state = 2;
    else           m_state = 0;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ptr   = '0;
    m_addr  = '0;
    m_data  = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sc"}, sc, 2'b00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ptr"}, ptr, '0);
    check({tag, "_data"}, data_out, 8'h00);
    check({tag, "_cs"}, ram_cs, 1'b0);
    check({tag, "_addr"}, ram_addr, '0);
    check({tag, "_tpa"}, tpa, 1'b0);
    check({tag, "_tpb"}, tpb, 1'b0);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 8'($urandom);
    reset      = 1'b1;
    ce         = 1'b1;
    dma_req    = 1'b0;
    int_req    = 1'b0;
    frame_base = '0;
    repeat (3) @(posedge clk);
    #1;
    ce    = 1'b0;
    reset = 1'b0;
    model_reset();
    check_all_zero("reset");

    // idle machine cycles: no fetches, one tpa/tpb per 8 ticks
    repeat (3) machine_cycle(1'b0, 1'b0);

    // interrupt acknowledge loads R0 from frame_base
    frame_base = 12'h300;
    machine_cycle(1'b0, 1'b1);
    machine_cycle(1'b0, 1'b0);
    check("t2_ptr", ptr, 12'h300);

    // one display line of 8 bytes
    for (int i = 0; i < 8; i++) mem[12'h300 + i] = 8'hA0 + 8'(i);
    machine_cycle(1'b1, 1'b0);
    repeat (7) machine_cycle(1'b1, 1'b0);
    check("t3_last_byte", data_out, 8'hA6);
    machine_cycle(1'b0, 1'b0);
    check("t3_ptr", ptr, 12'h308);
    check("t3_data", data_out, 8'hA7);
    check("t3_idle", sc, 2'b00);
    machine_cycle(1'b0, 1'b0);

    // simultaneous requests: DMA first, then INT
    frame_base = 12'h5A0;
    machine_cycle(1'b1, 1'b1);
    check("t4_dma_sc", sc, 2'b10);
    machine_cycle(1'b0, 1'b1);
    check("t4_int_sc", sc, 2'b11);
    machine_cycle(1'b0, 1'b0);
    check("t4_ptr", ptr, 12'h5A0);

    // pointer wrap at the top of the address space
    frame_base = 12'hFFF;
    machine_cycle(1'b0, 1'b1);
    machine_cycle(1'b0, 1'b0);
    machine_cycle(1'b1, 1'b0);
    machine_cycle(1'b0, 1'b0);
    check("t5_addr", ram_addr, 12'hFFF);
    check("t5_ptr", ptr, 12'h000);

    // random request mix
    for (int n = 0; n < 60; n++) begin
      frame_base = AW'($urandom);
      machine_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3));
    end

    // reset in the middle of a DMA burst
    repeat (2) machine_cycle(1'b1, 1'b0);
    check("t6_in_dma", sc, 2'b10);
    for (int k = 0; k < 4; k++) tick(2'b10, k);
    check("t6_cyc4_ptr", ptr, m_ptr);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("t6_rst");
    ce = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("t6_gated_sc", sc, 2'b00);
      check("t6_gated_ptr", ptr, '0);
      check("t6_gated_tpa", tpa, 1'b0);
    end
    model_reset();
    machine_cycle(1'b1, 1'b0);
    machine_cycle(1'b0, 1'b0);
    machine_cycle(1'b0, 1'b0);
    check("t6_restart_ptr", ptr, 12'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
